// File: rtl/branch_resolve_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolve_unit: D-stage branch resolver for the dual-issue front end. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module branch_resolve_unit #(
  parameter int CNT_W       = 32,
  parameter int INSTR_BYTES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_F,
  input  logic             fetchValid_F,
  input  logic [31:0]      pc_F1,
  input  logic [31:0]      pc_F2,
  input  logic             hit_F1,
  input  logic             predBJ_F1,
  input  logic             hit_F2,
  input  logic             predBJ_F2,
  input  logic [31:0]      predTarget_F1,
  input  logic [31:0]      predTarget_F2,
  input  logic             isBJ_D1,
  input  logic             isBJ_D2,
  input  logic             takenBJ_D1,
  input  logic             takenBJ_D2,
  input  logic [31:0]      targetPC_D1,
  input  logic [31:0]      targetPC_D2,
  output logic             valid_D,
  output logic [31:0]      pc_D1,
  output logic [31:0]      pc_D2,
  output logic             hit_D1,
  output logic             predBJ_D1,
  output logic             hit_D2,
  output logic             predBJ_D2,
  output logic             realBJ_D1,
  output logic             realBJ_D2,
  output logic             updBJ_D1,
  output logic             updBJ_D2,
  output logic             mispred_D,
  output logic [31:0]      redirectPC,
  output logic             flush_F,
  output logic [CNT_W-1:0] branchCount,
  output logic [CNT_W-1:0] mispredCount
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_SQUASH = 1'b1} state_t;

  localparam logic [31:0]      BUNDLE_STRIDE = 32'(2 * INSTR_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [31:0]       pc1_q, pc1_d, pc2_q, pc2_d;
  logic [31:0]       tgt1_q, tgt1_d, tgt2_q, tgt2_d;
  logic              hit1_q, hit1_d, hit2_q, hit2_d;
  logic              pred1_q, pred1_d, pred2_q, pred2_d;
  logic [CNT_W-1:0]  bcnt_q, bcnt_d, mcnt_q, mcnt_d;

  logic              live, live2, pt1, pt2, act1, act2, mis1, mis2, mispred;
  logic [31:0]       fall_thru, redirect;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  // Slot 2 only executes when slot 1 neither resolves nor was predicted taken.
  always_comb begin
    live      = valid_q & (state_q == ST_RUN);
    pt1       = live & hit1_q & pred1_q;
    act1      = live & isBJ_D1 & takenBJ_D1;
    live2     = live & ~act1 & ~pt1;
    pt2       = live2 & hit2_q & pred2_q;
    act2      = live2 & isBJ_D2 & takenBJ_D2;
    mis1      = (pt1 != act1) | (pt1 & act1 & (tgt1_q != targetPC_D1)) | (pt1 & ~isBJ_D1);
    mis2      = (pt2 != act2) | (pt2 & act2 & (tgt2_q != targetPC_D2)) | (pt2 & ~isBJ_D2);
    mispred   = (mis1 | mis2) & ~stall_F;
    fall_thru = pc1_q + BUNDLE_STRIDE;
    redirect  = '0;
    if (mis1)      redirect = act1 ? targetPC_D1 : fall_thru;
    else if (mis2) redirect = act2 ? targetPC_D2 : fall_thru;
  end

  // Predictor update strobes are held off during a stall so nothing is trained twice.
  assign updBJ_D1     = live  & isBJ_D1 & ~stall_F;
  assign updBJ_D2     = live2 & isBJ_D2 & ~stall_F;
  assign realBJ_D1    = act1 & ~stall_F;
  assign realBJ_D2    = act2 & ~stall_F;
  assign mispred_D    = mispred;
  assign flush_F      = mispred;
  assign redirectPC   = redirect;
  assign valid_D      = valid_q;
  assign pc_D1        = pc1_q;
  assign pc_D2        = pc2_q;
  assign hit_D1       = hit1_q;
  assign hit_D2       = hit2_q;
  assign predBJ_D1    = pred1_q;
  assign predBJ_D2    = pred2_q;
  assign branchCount  = bcnt_q;
  assign mispredCount = mcnt_q;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    pc1_d   = pc1_q;
    pc2_d   = pc2_q;
    tgt1_d  = tgt1_q;
    tgt2_d  = tgt2_q;
    hit1_d  = hit1_q;
    hit2_d  = hit2_q;
    pred1_d = pred1_q;
    pred2_d = pred2_q;
    bcnt_d  = bcnt_q;
    mcnt_d  = mcnt_q;
    if (!stall_F) begin
      // On a redirect, and in the cycle after it, the incoming bundle is wrong-path.
      if (mispred || state_q == ST_SQUASH) begin
        valid_d = 1'b0;
      end else begin
        valid_d = fetchValid_F;
        pc1_d   = pc_F1;
        pc2_d   = pc_F2;
        tgt1_d  = predTarget_F1;
        tgt2_d  = predTarget_F2;
        hit1_d  = hit_F1;
        hit2_d  = hit_F2;
        pred1_d = predBJ_F1;
        pred2_d = predBJ_F2;
      end
      state_d = (state_q == ST_RUN && mispred) ? ST_SQUASH : ST_RUN;
      bcnt_d  = sat_add(bcnt_q, {1'b0, updBJ_D1} + {1'b0, updBJ_D2});
      mcnt_d  = sat_add(mcnt_q, {1'b0, mispred});
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      pc1_q   <= '0;
      pc2_q   <= '0;
      tgt1_q  <= '0;
      tgt2_q  <= '0;
      hit1_q  <= 1'b0;
      hit2_q  <= 1'b0;
      pred1_q <= 1'b0;
      pred2_q <= 1'b0;
      bcnt_q  <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      pc1_q   <= pc1_d;
      pc2_q   <= pc2_d;
      tgt1_q  <= tgt1_d;
      tgt2_q  <= tgt2_d;
      hit1_q  <= hit1_d;
      hit2_q  <= hit2_d;
      pred1_q <= pred1_d;
      pred2_q <= pred2_d;
      bcnt_q  <= bcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Decode-stage resolver for the dual-issue front end.
- Captures per-slot fetch predictions (BTB hit, direction, predicted target) into an F->D pipeline register.
- Compares them with decoder-computed outcomes, generates redirect/flush and predictor-update signals, and keeps branch/mispredict statistics.
- Sits between fetch/predictor and the decoder; it is the producer of the D-stage resolution inputs the predictor consumes.

Parameters:
- CNT_W, 32, width of the statistics counters (saturating).
- INSTR_BYTES, 4, PC increment per slot; bundle stride is 2*INSTR_BYTES.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- stall_F  in  1  hold F->D register and FSM; suppress update strobes.
- fetchValid_F  in  1  fetch bundle valid.
- pc_F1, pc_F2  in  32  slot PCs in fetch.
- hit_F1, predBJ_F1, hit_F2, predBJ_F2  in  1 each  BTB hit and direction prediction in fetch.
- predTarget_F1, predTarget_F2  in  32  BTB target in fetch.
- isBJ_D1, isBJ_D2  in  1  decoder: slot is branch/jump.
- takenBJ_D1, takenBJ_D2  in  1  decoder: actual outcome.
- targetPC_D1, targetPC_D2  in  32  decoder: actual target.
- valid_D  out  1  D register holds a live bundle.
- pc_D1, pc_D2  out  32  registered slot PCs.
- hit_D1, predBJ_D1, hit_D2, predBJ_D2  out  1  registered predictions.
- realBJ_D1, realBJ_D2  out  1  qualified actual-taken flags to predictor.
- updBJ_D1, updBJ_D2  out  1  qualified isBJ flags to predictor.
- mispred_D  out  1  redirect strobe.
- redirectPC  out  32  corrected fetch PC.
- flush_F  out  1  kill fetch stage / F->D load.
- branchCount, mispredCount  out  CNT_W  statistics.

Behaviour:
- Reset (reset==0 at clk edge):
  - valid_D=0; all D registers 0; FSM=RUN; counters 0.
  - Combinational outputs are forced to 0 while valid_D=0.
- F->D register:
  - stall_F=1: hold.
  - Else if flush_F=1 or FSM=SQUASH: load valid_D=0.
  - Else: load all F fields, valid_D=fetchValid_F.
  - Latency is 1 cycle.
- Qualification (combinational, all terms ANDed with valid_D and FSM==RUN):
  - pt1 = hit_D1 & predBJ_D1; pt2 = hit_D2 & predBJ_D2.
  - updBJ_D1 = isBJ_D1; realBJ_D1 = isBJ_D1 & takenBJ_D1.
  - Slot 2 is live only if ~realBJ_D1 & ~pt1; updBJ_D2 and realBJ_D2 are otherwise 0.
- Mispredict, per live slot s:
  - Direction error: pt_s != realBJ_D_s.
  - Target error: pt_s & realBJ_D_s & (predTarget_s != targetPC_D_s).
  - Phantom branch: pt_s & ~isBJ_D_s.
- redirectPC, slot 1 has priority:
  - Slot-1 mispredict: realBJ_D1 ? targetPC_D1 : pc_D1+2*INSTR_BYTES.
  - Else slot-2 mispredict: realBJ_D2 ? targetPC_D2 : pc_D1+2*INSTR_BYTES.
  - Otherwise 0.
- mispred_D = flush_F = (either slot mispredicts) & ~stall_F. If stall_F=1, the strobe is held off until the stall clears. D is held, so the mispredict is re-evaluated then.
- FSM:
  - RUN->SQUASH on mispred_D.
  - SQUASH->RUN after exactly one non-stalled cycle. A stall in SQUASH holds the state.
  - In SQUASH, all update/redirect outputs are 0 and the D register reloads as invalid, killing the wrong-path bundle already in flight.
- Counters (non-stalled cycles only):
  - branchCount += updBJ_D1 + updBJ_D2.
  - mispredCount += mispred_D.
  - Both saturate at all-ones; no wrap.
- Simultaneous events:
  - Reset dominates stall.
  - A mispredict in the same cycle as stall produces no strobe and no counter change.
  - Both slots mispredicting: slot 1 only; counted once.

Test Plan:
- Reset mid-stream: hold reset=0 one edge while valid_D=1, mispredCount=5 -> valid_D=0, counts 0, FSM RUN, all strobes 0 next cycle.
- Correct prediction: pc_F1=0x100, hit_F1=1, predBJ_F1=1, predTarget_F1=0x200; next cycle isBJ_D1=1, takenBJ_D1=1, targetPC_D1=0x200 -> mispred_D=0, realBJ_D1=1, branchCount=1.
- Direction miss: pc_D1=0x40, pt1=0, isBJ_D1=1, takenBJ_D1=1, targetPC_D1=0x80 -> mispred_D=1, redirectPC=0x80, flush_F=1; next cycle FSM SQUASH, valid_D=0; cycle after, back to RUN.
- Target miss and phantom:
  - pt1=1, predTarget=0x300, targetPC_D1=0x304 -> redirect 0x304.
  - pt1=1, isBJ_D1=0, pc_D1=0x10 -> redirect 0x18.
- Slot priority and qualification:
  - Both slots mispredict -> redirect from slot 1, mispredCount +1.
  - realBJ_D1=1 -> updBJ_D2=0.
- Stall interaction: mispredict present with stall_F=1 for 3 cycles -> no strobe, D held; strobe fires on the first unstalled cycle. Separately, preload counters near max -> saturate at 2^CNT_W-1.
